// File: rtl/eq_pkg.sv
// Shared state encoding and datapath widths for the two-band equalizer sequencer.
package eq_pkg;

   localparam int SMP_W_DEFAULT = 16;
   localparam int BASS_W        = 20;
   localparam int HIGH_W        = 23;
   localparam int EQ_W          = 24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SUM    = 3'd3,
      ST_DONE   = 3'd4
   } eq_state_t;

endpackage

// File: rtl/eq_band_capture.sv
// Holds one band result and its got flag; captures once per sample on the first enabled ready.
module eq_band_capture #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         rdy,
   input  logic         force_zero,
   input  logic [W-1:0] data,
   output logic [W-1:0] cap,
   output logic         got,
   output logic         take
);

   logic [W-1:0] cap_reg;
   logic         got_reg;

   assign take = en & rdy & ~got_reg;
   assign cap  = cap_reg;
   assign got  = got_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_reg <= '0;
         got_reg <= 1'b0;
      end else if (clr) begin
         got_reg <= 1'b0;
      end else if (take) begin
         cap_reg <= data;
         got_reg <= 1'b1;
      end else if (force_zero && !got_reg) begin
         // a band that never answered contributes zero to the sum
         cap_reg <= '0;
         got_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/eq_band_sequencer.sv
// Per-sample controller: latches a codec sample, launches both band filters, collects
// their results (with timeout), and publishes the 24-bit sum with a one-cycle strobe.
module eq_band_sequencer
   import eq_pkg::*;
#(
   parameter int SMP_W       = SMP_W_DEFAULT,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_in_rdy,
   input  logic [SMP_W-1:0]  sample_in,
   output logic [SMP_W-1:0]  band_sample,
   output logic              start_bass,
   output logic              start_high,
   input  logic              rdy_bass,
   input  logic [BASS_W-1:0] in_bass,
   input  logic              rdy_high,
   input  logic [HIGH_W-1:0] in_high,
   output logic [EQ_W-1:0]   eq_out,
   output logic              eq_rdy,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err,
   input  logic              err_clr
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   eq_state_t         state_reg, state_next;
   logic [CNT_W-1:0]  tmo_cnt_reg;
   logic [SMP_W-1:0]  band_sample_reg;
   logic [EQ_W-1:0]   eq_out_reg;
   logic              eq_rdy_reg;
   logic              overrun_reg;
   logic              timeout_err_reg;

   logic accept, launch, wait_en, force_zero, set_tmo, set_ovr, do_sum;

   logic [BASS_W-1:0] cap_bass;
   logic [HIGH_W-1:0] cap_high;
   logic              got_bass, got_high, take_bass, take_high, all_done;
   logic [EQ_W-1:0]   sum_next;

   eq_band_capture #(.W(BASS_W)) u_bass (
      .clk        (clk),
      .rst        (rst),
      .clr        (launch),
      .en         (wait_en),
      .rdy        (rdy_bass),
      .force_zero (force_zero),
      .data       (in_bass),
      .cap        (cap_bass),
      .got        (got_bass),
      .take       (take_bass)
   );

   eq_band_capture #(.W(HIGH_W)) u_high (
      .clk        (clk),
      .rst        (rst),
      .clr        (launch),
      .en         (wait_en),
      .rdy        (rdy_high),
      .force_zero (force_zero),
      .data       (in_high),
      .cap        (cap_high),
      .got        (got_high),
      .take       (take_high)
   );

   // last outstanding band may be captured on this very edge
   assign all_done = (got_bass | take_bass) & (got_high | take_high);

   assign sum_next = {{(EQ_W-BASS_W){cap_bass[BASS_W-1]}}, cap_bass}
                   + {{(EQ_W-HIGH_W){cap_high[HIGH_W-1]}}, cap_high};

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      launch     = 1'b0;
      wait_en    = 1'b0;
      force_zero = 1'b0;
      set_tmo    = 1'b0;
      set_ovr    = 1'b0;
      do_sum     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (sample_in_rdy) begin
               accept     = 1'b1;
               state_next = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            launch     = 1'b1;
            set_ovr    = sample_in_rdy;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            wait_en = 1'b1;
            set_ovr = sample_in_rdy;
            if (all_done) begin
               state_next = ST_SUM;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               force_zero = 1'b1;
               set_tmo    = 1'b1;
               state_next = ST_SUM;
            end
         end
         ST_SUM: begin
            do_sum     = 1'b1;
            set_ovr    = sample_in_rdy;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            if (sample_in_rdy) begin
               accept     = 1'b1;
               state_next = ST_LAUNCH;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         tmo_cnt_reg     <= '0;
         band_sample_reg <= '0;
         eq_out_reg      <= '0;
         eq_rdy_reg      <= 1'b0;
         overrun_reg     <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         eq_rdy_reg <= do_sum;
         if (accept)
            band_sample_reg <= sample_in;
         if (launch)
            tmo_cnt_reg <= '0;
         else if (wait_en)
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         if (do_sum)
            eq_out_reg <= sum_next;
         // sticky flags: a set in the same cycle as err_clr wins
         if (set_ovr)
            overrun_reg <= 1'b1;
         else if (err_clr)
            overrun_reg <= 1'b0;
         if (set_tmo)
            timeout_err_reg <= 1'b1;
         else if (err_clr)
            timeout_err_reg <= 1'b0;
      end
   end

   assign band_sample = band_sample_reg;
   assign start_bass  = (state_reg == ST_LAUNCH);
   assign start_high  = (state_reg == ST_LAUNCH);
   assign eq_out      = eq_out_reg;
   assign eq_rdy      = eq_rdy_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign overrun     = overrun_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Randomized self-checking bench for eq_band_sequencer against a per-sample arithmetic model.
module tb_eq_band_sequencer;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_in_rdy = 1'b0;
   logic [15:0] sample_in = '0;
   logic [15:0] band_sample;
   logic        start_bass, start_high;
   logic        rdy_bass = 1'b0;
   logic [19:0] in_bass = '0;
   logic        rdy_high = 1'b0;
   logic [22:0] in_high = '0;
   logic [23:0] eq_out;
   logic        eq_rdy, busy, overrun, timeout_err;
   logic        err_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_sb = 0, n_sh = 0, n_eq = 0;

   eq_band_sequencer #(.SMP_W(16), .TIMEOUT_CYC(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_in_rdy (sample_in_rdy),
      .sample_in     (sample_in),
      .band_sample   (band_sample),
      .start_bass    (start_bass),
      .start_high    (start_high),
      .rdy_bass      (rdy_bass),
      .in_bass       (in_bass),
      .rdy_high      (rdy_high),
      .in_high       (in_high),
      .eq_out        (eq_out),
      .eq_rdy        (eq_rdy),
      .busy          (busy),
      .overrun       (overrun),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start_bass) n_sb++;
      if (start_high) n_sh++;
      if (eq_rdy)     n_eq++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      sample_in_rdy = 1'b0;
      rdy_bass = 1'b0;
      rdy_high = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Caller guarantees the DUT is in an accepting cycle (idle or result-done).
   // db/dh: WAIT-cycle index at which each band becomes ready (beyond TMO = never in time).
   task automatic run_sample(input string name, input logic [15:0] smp, input logic [19:0] vb,
                             input logic [22:0] vh, input int db, input int dh,
                             input int ovr_at, input bit hold);
      int          eb, eh, m, exp_cyc, k, sb0, sh0;
      bit          exp_tmo, exp_ovr, seen;
      logic [23:0] exp_eq;
      eb = $signed(vb);
      eh = $signed(vh);
      exp_tmo = (db > TMO) || (dh > TMO);
      exp_eq  = 24'((db <= TMO ? eb : 0) + (dh <= TMO ? eh : 0));
      m = (db > dh) ? db : dh;
      exp_cyc = (exp_tmo ? TMO : m) + 2;
      exp_ovr = (ovr_at > 0);
      sb0 = n_sb;
      sh0 = n_sh;

      sample_in = smp;
      sample_in_rdy = 1'b1;
      err_clr = 1'b1;
      rdy_bass = 1'b0;
      rdy_high = 1'b0;
      step();
      sample_in_rdy = 1'b0;
      err_clr = 1'b0;
      sample_in = $urandom;
      // LAUNCH cycle: stale ready levels with stale data must be ignored
      rdy_bass = hold;
      rdy_high = hold;
      in_bass = $urandom;
      in_high = $urandom;
      n_tests++;
      if (band_sample !== smp) begin
         n_fail++;
         $display("FAIL %s band_sample: got %h expected %h", name, band_sample, smp);
      end
      n_tests++;
      if ({start_bass, start_high, busy} !== 3'b111) begin
         n_fail++;
         $display("FAIL %s launch start_bass/start_high/busy: got %b expected 111", name,
                  {start_bass, start_high, busy});
      end

      k = 0;
      seen = 1'b0;
      while (!seen && k < TMO + 10) begin
         step();
         k++;
         rdy_bass = (k >= db);
         in_bass  = (k >= db) ? vb : 20'($urandom);
         rdy_high = (k >= dh);
         in_high  = (k >= dh) ? vh : 23'($urandom);
         sample_in_rdy = (k == ovr_at);
         if (k == ovr_at) sample_in = ~smp;
         if (exp_tmo && (k == TMO || k == TMO + 1)) begin
            n_tests++;
            if (timeout_err !== (k == TMO + 1)) begin
               n_fail++;
               $display("FAIL %s timeout_err at cycle %0d: got %b expected %b", name, k,
                        timeout_err, (k == TMO + 1));
            end
         end
         if (eq_rdy === 1'b1) seen = 1'b1;
      end
      sample_in_rdy = 1'b0;
      rdy_bass = 1'b0;
      rdy_high = 1'b0;

      n_tests++;
      if (!seen || k != exp_cyc) begin
         n_fail++;
         $display("FAIL %s eq_rdy latency: got cycle %0d (seen=%0d) expected cycle %0d", name,
                  k, seen, exp_cyc);
      end
      n_tests++;
      if (eq_out !== exp_eq) begin
         n_fail++;
         $display("FAIL %s eq_out: got %h expected %h", name, eq_out, exp_eq);
      end
      n_tests++;
      if ({timeout_err, overrun} !== {exp_tmo, exp_ovr}) begin
         n_fail++;
         $display("FAIL %s timeout_err/overrun: got %b%b expected %b%b", name, timeout_err,
                  overrun, exp_tmo, exp_ovr);
      end
      n_tests++;
      if (n_sb - sb0 != 1 || n_sh - sh0 != 1 || band_sample !== smp) begin
         n_fail++;
         $display("FAIL %s start counts/band_sample: got %0d/%0d %h expected 1/1 %h", name,
                  n_sb - sb0, n_sh - sh0, band_sample, smp);
      end
      $display("[TB] %s smp=%h bass=%h@%0d high=%h@%0d -> eq_out=%h lat=%0d", name, smp, vb,
               db, vh, dh, eq_out, k);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tests++;
      if ({band_sample, start_bass, start_high, eq_out, eq_rdy, busy, overrun, timeout_err}
          !== '0) begin
         n_fail++;
         $display("FAIL reset outputs: got smp=%h sb=%b sh=%b eq=%h rdy=%b busy=%b ovr=%b tmo=%b expected all 0",
                  band_sample, start_bass, start_high, eq_out, eq_rdy, busy, overrun, timeout_err);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      run_sample("basic", 16'h1234, 20'd1000, -23'sd300, 3, 5, 0, 1'b0);
      idle_cycles(1);
      n_tests++;
      if (busy !== 1'b0 || eq_out !== 24'd700) begin
         n_fail++;
         $display("FAIL basic hold: got busy=%b eq_out=%h expected 0 0002bc", busy, eq_out);
      end
   endtask

   task automatic test_extremes();
      run_sample("max", 16'h0001, 20'h7FFFF, 23'h3FFFFF, 1, 1, 0, 1'b0);
      idle_cycles(2);
      run_sample("min", 16'h8000, 20'h80000, 23'h400000, 2, 2, 0, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_timeout();
      run_sample("timeout", 16'h00AA, 20'd50, 23'd7, 1, 1000, 0, 1'b0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      step();
      n_tests++;
      if (timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout err_clr: got %b expected 0", timeout_err);
      end
      idle_cycles(1);
   endtask

   task automatic test_overrun_and_chain();
      run_sample("overrun", 16'h5A5A, 20'd123, 23'd456, 4, 2, 2, 1'b0);
      // strobe while the result is being presented: accepted without overrun
      run_sample("chain", 16'hA5A5, -20'sd9, 23'd10, 1, 3, 0, 1'b0);
      idle_cycles(2);
   endtask

   task automatic test_reset_mid();
      int sb0, eq0;
      sample_in = 16'h7777;
      sample_in_rdy = 1'b1;
      step();
      sample_in_rdy = 1'b0;
      step();
      step();
      sb0 = n_sb;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if ({band_sample, start_bass, start_high, eq_out, eq_rdy, busy, overrun, timeout_err}
          !== '0) begin
         n_fail++;
         $display("FAIL reset_mid outputs: got smp=%h eq=%h rdy=%b busy=%b expected all 0",
                  band_sample, eq_out, eq_rdy, busy);
      end
      eq0 = n_eq;
      rdy_bass = 1'b1;
      rdy_high = 1'b1;
      for (int i = 0; i < 5; i++) step();
      rdy_bass = 1'b0;
      rdy_high = 1'b0;
      n_tests++;
      if (n_eq != eq0 || n_sb != sb0) begin
         n_fail++;
         $display("FAIL reset_mid quiet: got eq_rdy=%0d starts=%0d expected 0 0", n_eq - eq0,
                  n_sb - sb0);
      end
      run_sample("after_reset", 16'h0F0F, 20'd5, 23'd6, 2, 1, 0, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_stale_ready();
      run_sample("stale_rdy", 16'h3333, 20'd77, -23'sd1, 1, 1, 0, 1'b1);
      idle_cycles(1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int db, dh, ov;
         db = $urandom_range(1, 20);
         dh = $urandom_range(1, 20);
         ov = ($urandom_range(0, 3) == 0) ? 1 : 0;
         run_sample("random", 16'($urandom), 20'($urandom), 23'($urandom), db, dh, ov, 1'b0);
         idle_cycles($urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_timeout();
      test_overrun_and_chain();
      test_reset_mid();
      test_stale_ready();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
